// File: rtl/sort_feeder.sv
// sort_feeder: streaming front-end for a 4-input sort engine.
// Collects a group of 1..4 words from a valid/ready input stream and pads
// the unused lanes with PAD_VALUE. It then kicks the sorter, waits for
// completion, captures the sorted lanes and replays the real words on a
// valid/ready output stream.
// Build option: define SORT_FEEDER_DESCEND_EN to replay the group largest
// first. When it is undefined, the group is replayed smallest first.
module sort_feeder #(
    parameter int unsigned      WIDTH         = 32,
    parameter logic [WIDTH-1:0] PAD_VALUE     = '1,
    parameter int unsigned      START_TIMEOUT = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sort_input_0,
    output logic [WIDTH-1:0] sort_input_1,
    output logic [WIDTH-1:0] sort_input_2,
    output logic [WIDTH-1:0] sort_input_3,
    input  logic [WIDTH-1:0] sort_output_0,
    input  logic [WIDTH-1:0] sort_output_1,
    input  logic [WIDTH-1:0] sort_output_2,
    input  logic [WIDTH-1:0] sort_output_3,
    output logic             sort_kick,
    input  logic             sort_busy,
    output logic             busy
);

    // Timer counts 0..START_TIMEOUT-1 while waiting for the sorter to start.
    localparam int unsigned   TW         = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(START_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_FILL,
        ST_KICK,
        ST_WAIT_START,
        ST_WAIT_DONE,
        ST_CAPTURE,
        ST_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       count_q, count_d;       // words already held in this group
    logic [1:0]       last_idx_q, last_idx_d; // index of the last real word (n-1)
    logic [TW-1:0]    timer_q, timer_d;
    logic [1:0]       idx_q, idx_d;           // result lane currently presented
    logic [WIDTH-1:0] lane_q [4];
    logic [WIDTH-1:0] lane_d [4];
    logic [WIDTH-1:0] result_q [4];
    logic [WIDTH-1:0] result_d [4];
    logic [WIDTH-1:0] sort_out_w [4];

    logic             fill_accept;
    logic             fill_final;
    logic             drain_last;
    logic             capture_en;
    logic [3:0]       lane_wr;
    logic [3:0]       lane_pad;

    assign sort_out_w[0] = sort_output_0;
    assign sort_out_w[1] = sort_output_1;
    assign sort_out_w[2] = sort_output_2;
    assign sort_out_w[3] = sort_output_3;

    assign sort_input_0 = lane_q[0];
    assign sort_input_1 = lane_q[1];
    assign sort_input_2 = lane_q[2];
    assign sort_input_3 = lane_q[3];

    // A word is taken whenever it is offered in FILL.
    // The group closes on its 4th word or on an explicit in_last.
    assign fill_accept = (state_q == ST_FILL) && in_valid;
    assign fill_final  = in_last || (count_q == 2'd3);
    assign capture_en  = (state_q == ST_CAPTURE);

`ifdef SORT_FEEDER_DESCEND_EN
    // Largest-first replay walks the result lanes downward and ends at lane 0.
    assign drain_last = (idx_q == 2'd0);
`else
    // Smallest-first replay walks the result lanes upward and ends at lane n-1.
    assign drain_last = (idx_q == last_idx_q);
`endif

    // Per-lane decode: the lane at count takes the word.
    // On the closing word, every higher lane takes the pad value.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane_dec
            assign lane_wr[gi]  = fill_accept && (count_q == 2'(gi));
            assign lane_pad[gi] = fill_accept && fill_final && (2'(gi) > count_q);
        end
    endgenerate

    // Next value of the sorter input lanes and of the captured result lanes.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_d[k]   = lane_q[k];
            result_d[k] = result_q[k];
            if (lane_wr[k]) begin
                lane_d[k] = in_data;
            end else if (lane_pad[k]) begin
                lane_d[k] = PAD_VALUE;
            end
            if (capture_en) begin
                result_d[k] = sort_out_w[k];
            end
        end
    end

    // FSM next-state and bookkeeping counters.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        last_idx_d = last_idx_q;
        timer_d    = timer_q;
        idx_d      = idx_q;
        case (state_q)
            ST_FILL: begin
                if (fill_accept) begin
                    if (fill_final) begin
                        state_d    = ST_KICK;
                        count_d    = 2'd0;
                        last_idx_d = count_q;
                    end else begin
                        count_d = count_q + 2'd1;
                    end
                end
            end
            ST_KICK: begin
                timer_d = '0;
                state_d = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                // A sorter that never raises busy is treated as done after the timeout.
                if (sort_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = ST_CAPTURE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!sort_busy) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
`ifdef SORT_FEEDER_DESCEND_EN
                idx_d = last_idx_q;
`else
                idx_d = 2'd0;
`endif
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (drain_last) begin
                        state_d = ST_FILL;
                    end else begin
`ifdef SORT_FEEDER_DESCEND_EN
                        idx_d = idx_q - 2'd1;
`else
                        idx_d = idx_q + 2'd1;
`endif
                    end
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // Stream and sorter handshake outputs, decoded from the registered state.
    always_comb begin
        in_ready  = (state_q == ST_FILL);
        sort_kick = (state_q == ST_KICK);
        out_valid = (state_q == ST_DRAIN);
        out_data  = '0;
        out_last  = 1'b0;
        if (state_q == ST_DRAIN) begin
            out_data = result_q[idx_q];
            out_last = drain_last;
        end
        busy = !((state_q == ST_FILL) && (count_q == 2'd0));
    end

    // State and datapath registers. Reset abandons any group in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_FILL;
            count_q    <= 2'd0;
            last_idx_q <= 2'd0;
            timer_q    <= '0;
            idx_q      <= 2'd0;
            for (int k = 0; k < 4; k++) begin
                lane_q[k]   <= '0;
                result_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            last_idx_q <= last_idx_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            for (int k = 0; k < 4; k++) begin
                lane_q[k]   <= lane_d[k];
                result_q[k] <= result_d[k];
            end
        end
    end

endmodule

// File: tb/tb_sort_feeder.sv
// Testbench for sort_feeder: a table of directed groups, a randomized group
// stream checked against a list-sorting reference, and a mid-drain reset.
module tb_sort_feeder;

    localparam int unsigned START_TIMEOUT = 4;
    localparam logic [31:0] PAD = 32'hFFFF_FFFF;
`ifdef SORT_FEEDER_DESCEND_EN
    localparam bit DESC = 1'b1;
`else
    localparam bit DESC = 1'b0;
`endif

    logic        CLK;
    logic        RST;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic [31:0] sort_input_0, sort_input_1, sort_input_2, sort_input_3;
    logic [31:0] sort_output_0, sort_output_1, sort_output_2, sort_output_3;
    logic        sort_kick;
    logic        sort_busy;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    sort_feeder #(
        .WIDTH(32),
        .PAD_VALUE(PAD),
        .START_TIMEOUT(START_TIMEOUT)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_last(in_last),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_last(out_last),
        .out_ready(out_ready),
        .sort_input_0(sort_input_0),
        .sort_input_1(sort_input_1),
        .sort_input_2(sort_input_2),
        .sort_input_3(sort_input_3),
        .sort_output_0(sort_output_0),
        .sort_output_1(sort_output_1),
        .sort_output_2(sort_output_2),
        .sort_output_3(sort_output_3),
        .sort_kick(sort_kick),
        .sort_busy(sort_busy),
        .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Sorter stand-in. In busy mode it raises busy one cycle after kick for
    // five cycles and shows junk while busy. Otherwise it never raises busy
    // and presents the sorted lanes combinationally.
    bit         busy_mode;
    logic [2:0] sb_cnt;
    logic [3:0][31:0] srt;

    function automatic logic [3:0][31:0] sort4(input logic [3:0][31:0] v);
        logic [3:0][31:0] r;
        logic [31:0] t;
        r = v;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 3 - i; j++)
                if (r[j] > r[j+1]) begin
                    t = r[j]; r[j] = r[j+1]; r[j+1] = t;
                end
        return r;
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) sb_cnt <= 3'd0;
        else if (sort_kick && busy_mode) sb_cnt <= 3'd5;
        else if (sb_cnt != 3'd0) sb_cnt <= sb_cnt - 3'd1;
    end
    assign sort_busy = (sb_cnt != 3'd0);
    assign srt = sort4({sort_input_3, sort_input_2, sort_input_1, sort_input_0});
    assign sort_output_0 = sort_busy ? 32'hDEAD_BEEF : srt[0];
    assign sort_output_1 = sort_busy ? 32'hDEAD_BEEF : srt[1];
    assign sort_output_2 = sort_busy ? 32'hDEAD_BEEF : srt[2];
    assign sort_output_3 = sort_busy ? 32'hDEAD_BEEF : srt[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0][31:0] mk4(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c, input logic [31:0] d);
        logic [3:0][31:0] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    // Reference: the real words of the group in replay order (pads never appear).
    function automatic logic [3:0][31:0] ref_order(input logic [3:0][31:0] w, input int n);
        logic [31:0] q[$];
        logic [31:0] t;
        logic [3:0][31:0] r;
        for (int i = 0; i < n; i++) q.push_back(w[i]);
        for (int i = 0; i < n; i++)
            for (int j = i + 1; j < n; j++)
                if (q[j] < q[i]) begin t = q[i]; q[i] = q[j]; q[j] = t; end
        r = '0;
        for (int i = 0; i < n; i++) r[i] = DESC ? q[n-1-i] : q[i];
        return r;
    endfunction

    // Same order rule applied to an ascending hand-written expectation.
    function automatic logic [3:0][31:0] orient(input logic [3:0][31:0] e, input int n);
        logic [3:0][31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = DESC ? e[n-1-i] : e[i];
        return r;
    endfunction

    // Feed one group, drain it and check data, last, kick, lanes, stalls and latency.
    task automatic run_group(input string tag, input logic [3:0][31:0] w, input int n,
                             input int rmode, input bit hold, input logic [3:0][31:0] e,
                             input bit smode);
        int sent = 0, got = 0, cyc = 0, kicks = 0;
        int kick_cyc = -1, acc_cyc = -1, fall_cyc = -1, fv_cyc = -1;
        bit prev_busy = 0, prev_stall = 0, done = 0;
        logic [31:0] prev_data = '0;
        logic prev_last = 1'b0;
        busy_mode = smode;
        while (!done && cyc < 300) begin
            @(negedge CLK);
            cyc++;
            if (sent < n) begin
                in_valid = 1'b1; in_data = w[sent]; in_last = (sent == n - 1);
            end else begin
                in_valid = hold; in_data = 32'h0BAD_0000 + 32'(cyc); in_last = hold;
            end
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = (cyc % 2) == 1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (in_valid) begin
                if (sent < n) begin
                    if (in_ready) begin
                        if (sent == n - 1) acc_cyc = cyc;
                        sent++;
                    end
                end else begin
                    chk({tag, " in_ready_blocked"}, 32'(in_ready), 32'd0);
                end
            end
            if (sort_kick) begin
                kicks++;
                kick_cyc = cyc;
                chk({tag, " lane0"}, sort_input_0, (n > 0) ? w[0] : PAD);
                chk({tag, " lane1"}, sort_input_1, (n > 1) ? w[1] : PAD);
                chk({tag, " lane2"}, sort_input_2, (n > 2) ? w[2] : PAD);
                chk({tag, " lane3"}, sort_input_3, (n > 3) ? w[3] : PAD);
            end
            if (prev_busy && !sort_busy && fall_cyc < 0) fall_cyc = cyc;
            prev_busy = sort_busy;
            if (out_valid && fv_cyc < 0) fv_cyc = cyc;
            if (prev_stall) begin
                chk({tag, " stall_valid"}, 32'(out_valid), 32'd1);
                chk({tag, " stall_data"}, out_data, prev_data);
                chk({tag, " stall_last"}, 32'(out_last), 32'(prev_last));
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (out_valid && out_ready) begin
                chk($sformatf("%s word%0d", tag, got), out_data, (got < 4) ? e[got] : 32'hx);
                chk($sformatf("%s last%0d", tag, got), 32'(out_last), 32'(got == n - 1));
                got++;
                if (out_last || got >= n) done = 1;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk({tag, " completed"}, 32'(done), 32'd1);
        chk({tag, " words"}, 32'(got), 32'(n));
        chk({tag, " kicks"}, 32'(kicks), 32'd1);
        chk({tag, " kick_lat"}, 32'(kick_cyc), 32'(acc_cyc + 1));
        if (smode) chk({tag, " out_lat"}, 32'(fv_cyc), 32'(fall_cyc + 2));
        else       chk({tag, " out_lat"}, 32'(fv_cyc), 32'(kick_cyc + int'(START_TIMEOUT) + 2));
        @(negedge CLK);
        #1;
        chk({tag, " idle_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, " idle_busy"}, 32'(busy), 32'd0);
        chk({tag, " idle_out_valid"}, 32'(out_valid), 32'd0);
        $display("group %s n=%0d ready_mode=%0d sorter_busy=%0d words=%0d", tag, n, rmode, smode, got);
    endtask

    typedef struct packed {
        logic [3:0][31:0] w;
        logic [3:0][31:0] e;
        logic [2:0]       n;
        logic [1:0]       rmode;
        logic             hold;
        logic             smode;
    } vec_t;

    function automatic vec_t mkv(input logic [3:0][31:0] w, input logic [3:0][31:0] e,
                                 input int n, input int rmode, input bit hold, input bit smode);
        vec_t v;
        v.w = w; v.e = e; v.n = 3'(n); v.rmode = 2'(rmode); v.hold = hold; v.smode = smode;
        return v;
    endfunction

    vec_t tbl[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][31:0] w;
        int n, guard;

        tbl[0] = mkv(mk4(4, 3, 2, 1),       mk4(1, 2, 3, 4),       4, 0, 0, 1); // full group
        tbl[1] = mkv(mk4(9, 7, 32'h55, 0),  mk4(7, 9, 0, 0),       2, 0, 0, 1); // short group
        tbl[2] = mkv(mk4(4, 3, 2, 1),       mk4(1, 2, 3, 4),       4, 1, 1, 1); // toggling ready
        tbl[3] = mkv(mk4(30, 10, 20, 5),    mk4(5, 10, 20, 30),    4, 0, 0, 0); // no busy
        tbl[4] = mkv(mk4(5, 8, 1, 1),       mk4(1, 1, 5, 8),       4, 0, 1, 1); // back-to-back a
        tbl[5] = mkv(mk4(0, 6, 6, 6),       mk4(0, 0, 0, 0),       1, 0, 1, 1); // back-to-back b
        tbl[6] = mkv(mk4(PAD, 3, PAD, 77),  mk4(3, PAD, PAD, 0),   3, 2, 0, 0); // real pad-valued words
        tbl[7] = mkv(mk4(42, 1, 2, 3),      mk4(42, 0, 0, 0),      1, 1, 0, 0); // single, no busy

        RST = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        busy_mode = 1'b1;
        #1 RST = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_last", 32'(out_last), 32'd0);
        chk("rst out_data", out_data, 32'd0);
        chk("rst sort_kick", 32'(sort_kick), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst sort_input_0", sort_input_0, 32'd0);
        chk("rst sort_input_3", sort_input_3, 32'd0);
        RST = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_group($sformatf("tbl%0d", i), tbl[i].w, int'(tbl[i].n), int'(tbl[i].rmode),
                      tbl[i].hold, orient(tbl[i].e, int'(tbl[i].n)), tbl[i].smode);
        end

        for (int i = 0; i < 30; i++) begin
            n = $urandom_range(1, 4);
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 3))
                    0: w[k] = 32'($urandom_range(0, 3));
                    3: w[k] = PAD;
                    default: w[k] = $urandom;
                endcase
            end
            run_group($sformatf("rnd%0d", i), w, n, $urandom_range(0, 2),
                      1'($urandom_range(0, 1)), ref_order(w, n), 1'($urandom_range(0, 1)));
        end

        // Reset while the output stream is mid-drain: everything drops at once.
        busy_mode = 1'b1;
        out_ready = 1'b0;
        w = mk4(4, 3, 2, 1);
        n = 0;
        guard = 0;
        while (n < 4 && guard < 50) begin
            @(negedge CLK);
            guard++;
            in_valid = 1'b1; in_data = w[n]; in_last = (n == 3);
            #1;
            if (in_ready) n++;
        end
        @(negedge CLK);
        in_valid = 1'b0; in_last = 1'b0;
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        chk("t1 reached_drain", 32'(out_valid), 32'd1);
        #2 RST = 1'b0;
        #1;
        chk("t1 out_valid", 32'(out_valid), 32'd0);
        chk("t1 in_ready", 32'(in_ready), 32'd1);
        chk("t1 sort_kick", 32'(sort_kick), 32'd0);
        chk("t1 out_data", out_data, 32'd0);
        chk("t1 busy", 32'(busy), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            #1;
            chk($sformatf("t1 post_valid%0d", c), 32'(out_valid), 32'd0);
        end
        $display("group t1 reset mid-drain checked");

        // The feeder must still work normally after the abandoned group.
        run_group("post_rst", mk4(12, 11, 13, 0), 3, 0, 0, orient(mk4(11, 12, 13, 0), 3), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
